rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Round-robin arbiter that shares one 4:1 multiplexer output channel among four requesters (inputs a, b, c, d mapped to requesters 0..3).
- Drives the mux select `sel` and a one-hot grant to the requesters.
- Bounds each ownership to HOLD_MAX cycles so no requester can starve the others.
- Sits directly in front of the mux4_1 select input.

Parameters:
- HOLD_MAX, 4, maximum consecutive cycles one requester may hold the grant. Legal range: 1..15.
- CW, 4, width of the internal hold counter. Must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[i] is requester i (0=a, 1=b, 2=c, 3=d).
- grant  output  4  one-hot grant; all zeros when idle.
- sel  output  2  mux select; equals the index of the granted requester.
- busy  output  1  high while any grant is active.

Behaviour:
- All outputs are registered.
- Reset is asynchronous and active-high. Reset values:
  - grant=4'b0000, sel=2'b00, busy=0.
  - Internal state=IDLE, priority pointer ptr=2'd0, hold counter cnt=0.
- Reset asserted mid-grant drops grant immediately, without waiting for a clock edge.
- States: IDLE, OWN.
- IDLE:
  - If req==0: stay in IDLE; grant=0, sel holds its last value, busy=0.
  - Else: choose the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: grant[i]=1, sel=i, busy=1, cnt=1, go to OWN.
  - Latency from request to grant: 1 cycle from IDLE.
- OWN (owner o = sel):
  - Release when req[o]==0 sampled at a clock edge, or when cnt==HOLD_MAX.
  - On release edge: grant=0, busy=0, ptr=o+1 (mod 4, 3 wraps to 0), cnt=0, go to IDLE.
  - Otherwise: cnt=cnt+1 and grant holds.
- There is always exactly one IDLE bubble cycle between consecutive grants; this is mandatory.
- Maximum continuous ownership is HOLD_MAX cycles. With HOLD_MAX=1, every grant lasts exactly 1 cycle.
- Requests from non-owners during OWN are ignored until the next IDLE evaluation; they are not latched.
- Simultaneous case: if the owner drops its request on the same edge that cnt reaches HOLD_MAX, release happens once, with a normal ptr update.
- sel only changes on a new grant. It holds its value during IDLE so the mux output stays stable.
- Invariants:
  - grant is always one-hot or zero.
  - busy == |grant.
  - When busy=1, sel == index of the set bit in grant.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds port `lock  input  1`.
  - While in OWN with lock=1, the HOLD_MAX limit is suppressed: cnt saturates at HOLD_MAX and the owner keeps the grant until req[o] drops.
  - lock has no effect in IDLE.
- When undefined:
  - The port does not exist and HOLD_MAX is always enforced.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> grant=0000, busy=0, sel=00 throughout. Assert reset mid-grant -> grant=0000 immediately (asynchronously), ptr back to 0.
- Single requester: req=4'b0100 held 10 cycles, HOLD_MAX=4 -> grant=0100 and sel=10 for 4 cycles, 1 idle cycle, then 4 grant cycles again, repeating.
- All requesting: req=4'b1111 continuous, HOLD_MAX=2 -> grant sequence 0001, 0010, 0100, 1000, 0001, each 2 cycles followed by 1 idle cycle; sel=00, 01, 10, 11, 00.
- Early release: req=4'b0011; requester 0 drops after 1 cycle of grant -> grant=0000 next edge, then grant=0010 and sel=01 one cycle later.
- Wrap-around: ptr=3 after granting requester 2, then req=4'b0101 -> requester 0 is granted (scan 3, 0); sel=00.
- With ARB_LOCK_EN defined: req=4'b1001, grant to requester 0, lock=1 for 8 cycles -> grant=0001 for all 8 cycles. Deassert lock after cnt has saturated -> release on the next edge, then requester 3 is granted.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter driving a 4:1 mux select with a bounded hold time.
// Optional ARB_LOCK_EN adds a lock input that lets the owner exceed HOLD_MAX.
module rr_arbiter4 #(
    parameter int HOLD_MAX = 4,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;

    logic            pick_vld_s;
    logic [1:0]      pick_s;
    logic            at_max_s;
    logic            limit_hit_s;
    logic            owner_req_s;

    // Rotating priority scan starting at ptr_q; first active request wins.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_s     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!pick_vld_s && req[2'(ptr_q + 2'(k))]) begin
                pick_vld_s = 1'b1;
                pick_s     = 2'(ptr_q + 2'(k));
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Hold-limit detection; a held lock masks the limit while owning.
    always_comb begin
        at_max_s    = (cnt_q == CW'(HOLD_MAX));
        owner_req_s = req[sel_q];
`ifdef ARB_LOCK_EN
        limit_hit_s = at_max_s && !lock;
`else
        limit_hit_s = at_max_s;
`endif
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    grant_d = 4'b0001 << pick_s;
                    sel_d   = pick_s;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = ST_OWN;
                end else begin
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            ST_OWN: begin
                if (!owner_req_s || limit_hit_s) begin
                    // Release always passes through one idle cycle.
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    cnt_d   = CW'(0);
                    state_d = ST_IDLE;
                end else if (at_max_s) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                cnt_d   = CW'(0);
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= CW'(0);
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: directed vectors push expectations, a monitor pops and compares.
module tb_rr_arbiter4;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req4, req2;
    logic [3:0] g4, g2;
    logic [1:0] s4, s2;
    logic       b4, b2;
`ifdef ARB_LOCK_EN
    logic       lock4, lock2;
`endif

    exp_t q4[$];
    exp_t q2[$];
    int   checks;
    int   failures;
    int   n4;
    int   n2;

    rr_arbiter4 #(.HOLD_MAX(4), .CW(4)) u_h4 (
        .clk(clk), .reset(reset), .req(req4),
`ifdef ARB_LOCK_EN
        .lock(lock4),
`endif
        .grant(g4), .sel(s4), .busy(b4)
    );

    rr_arbiter4 #(.HOLD_MAX(2), .CW(4)) u_h2 (
        .clk(clk), .reset(reset), .req(req2),
`ifdef ARB_LOCK_EN
        .lock(lock2),
`endif
        .grant(g2), .sel(s2), .busy(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: 1 time unit after each edge, compare outputs against queued expectations.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            n4++;
            checks++;
            if ({g4, s4, b4} !== {e.g, e.s, e.b}) begin
                failures++;
                $display("FAIL h4_step%0d: got grant=%b sel=%0d busy=%b, expected grant=%b sel=%0d busy=%b",
                         n4, g4, s4, b4, e.g, e.s, e.b);
            end
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            n2++;
            checks++;
            if ({g2, s2, b2} !== {e.g, e.s, e.b}) begin
                failures++;
                $display("FAIL h2_step%0d: got grant=%b sel=%0d busy=%b, expected grant=%b sel=%0d busy=%b",
                         n2, g2, s2, b2, e.g, e.s, e.b);
            end
        end
    end

    task automatic step(input int dut, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] s, input logic b);
        exp_t e;
        e.g = g;
        e.s = s;
        e.b = b;
        if (dut == 2) begin
            req2 = r;
            q2.push_back(e);
        end else begin
            req4 = r;
            q4.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n4       = 0;
        n2       = 0;
        reset    = 1'b1;
        req4     = 4'b0000;
        req2     = 4'b0000;
`ifdef ARB_LOCK_EN
        lock4    = 1'b0;
        lock2    = 1'b0;
`endif
        #1;
        checks++;
        if ({g4, s4, b4, g2, s2, b2} !== 14'b0) begin
            failures++;
            $display("FAIL reset_state: got h4=%b/%0d/%b h2=%b/%0d/%b, expected all zero", g4, s4, b4, g2, s2, b2);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) step(4, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Single requester 2 with HOLD_MAX=4: 4 grant cycles then 1 idle, twice.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 4; i++) step(4, 4'b0100, 4'b0100, 2'd2, 1'b1);
            step(4, 4'b0100, 4'b0000, 2'd2, 1'b0);
        end
        step(4, 4'b0000, 4'b0000, 2'd2, 1'b0);

        // Early release: ptr=3, req 0011 scans 3,0 -> requester 0; drop it after one cycle.
        step(4, 4'b0011, 4'b0001, 2'd0, 1'b1);
        step(4, 4'b0010, 4'b0000, 2'd0, 1'b0);
        step(4, 4'b0010, 4'b0010, 2'd1, 1'b1);
        step(4, 4'b0000, 4'b0000, 2'd1, 1'b0);

        // Wrap-around: grant requester 2 so ptr becomes 3, then 0101 -> requester 0.
        step(4, 4'b0100, 4'b0100, 2'd2, 1'b1);
        step(4, 4'b0000, 4'b0000, 2'd2, 1'b0);
        step(4, 4'b0101, 4'b0001, 2'd0, 1'b1);
        step(4, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Mid-grant reset clears outputs without a clock edge; ptr returns to 0.
        step(4, 4'b1000, 4'b1000, 2'd3, 1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if ({g4, s4, b4} !== 7'b0) begin
            failures++;
            $display("FAIL async_reset: got grant=%b sel=%0d busy=%b, expected grant=0000 sel=0 busy=0", g4, s4, b4);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        req4  = 4'b0000;
        step(4, 4'b1001, 4'b0001, 2'd0, 1'b1);
        step(4, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // All requesting with HOLD_MAX=2; the final drop coincides with cnt reaching the limit.
        step(2, 4'b1111, 4'b0001, 2'd0, 1'b1);
        step(2, 4'b1111, 4'b0001, 2'd0, 1'b1);
        step(2, 4'b1111, 4'b0000, 2'd0, 1'b0);
        step(2, 4'b1111, 4'b0010, 2'd1, 1'b1);
        step(2, 4'b1111, 4'b0010, 2'd1, 1'b1);
        step(2, 4'b1111, 4'b0000, 2'd1, 1'b0);
        step(2, 4'b1111, 4'b0100, 2'd2, 1'b1);
        step(2, 4'b1111, 4'b0100, 2'd2, 1'b1);
        step(2, 4'b1111, 4'b0000, 2'd2, 1'b0);
        step(2, 4'b1111, 4'b1000, 2'd3, 1'b1);
        step(2, 4'b1111, 4'b1000, 2'd3, 1'b1);
        step(2, 4'b1111, 4'b0000, 2'd3, 1'b0);
        step(2, 4'b1111, 4'b0001, 2'd0, 1'b1);
        step(2, 4'b1111, 4'b0001, 2'd0, 1'b1);
        step(2, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(2, 4'b0000, 4'b0000, 2'd0, 1'b0);

`ifdef ARB_LOCK_EN
        // Lock keeps requester 0 past HOLD_MAX; dropping lock releases, then requester 3 wins.
        do_reset();
        lock4 = 1'b1;
        for (int i = 0; i < 8; i++) step(4, 4'b1001, 4'b0001, 2'd0, 1'b1);
        lock4 = 1'b0;
        step(4, 4'b1001, 4'b0000, 2'd0, 1'b0);
        step(4, 4'b1001, 4'b1000, 2'd3, 1'b1);
        step(4, 4'b0000, 4'b0000, 2'd3, 1'b0);
`endif

        @(posedge clk);
        #3;
        checks++;
        if ((q4.size() + q2.size()) != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q4.size() + q2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
